// File: rtl/hls_multibuf_channel_if.sv
// Producer/consumer bundle of the N-buffer channel: commit/release handshakes,
// occupancy, flush and the two random-access RAM ports.
interface hls_multibuf_channel_if #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 5,
    parameter int IndexWidth   = 1
);
    logic                    flush;

    logic                    i_ce;
    logic                    i_write;
    logic                    i_full_n;
    logic [IndexWidth:0]     i_count;
    logic                    i_ce0;
    logic                    i_we0;
    logic [AddressWidth-1:0] i_address0;
    logic [DataWidth-1:0]    i_d0;
    logic [DataWidth-1:0]    i_q0;

    logic                    t_ce;
    logic                    t_read;
    logic                    t_empty_n;
    logic [IndexWidth:0]     t_count;
    logic                    t_ce0;
    logic                    t_we0;
    logic [AddressWidth-1:0] t_address0;
    logic [DataWidth-1:0]    t_d0;
    logic [DataWidth-1:0]    t_q0;

    modport slave (
        input  flush,
        input  i_ce, i_write, i_ce0, i_we0, i_address0, i_d0,
        input  t_ce, t_read, t_ce0, t_we0, t_address0, t_d0,
        output i_full_n, i_count, i_q0,
        output t_empty_n, t_count, t_q0
    );

    modport master (
        output flush,
        output i_ce, i_write, i_ce0, i_we0, i_address0, i_d0,
        output t_ce, t_read, t_ce0, t_we0, t_address0, t_d0,
        input  i_full_n, i_count, i_q0,
        input  t_empty_n, t_count, t_q0
    );
endinterface

// File: rtl/hls_multibuf_channel.sv
// N-buffer dataflow channel: buffer ownership passes from producer to consumer
// on commit and back on release; both sides see one buffer through a RAM port.
module hls_multibuf_channel #(
    parameter int DataWidth    = 32,
    parameter int AddressRange = 32,
    parameter int AddressWidth = 5,
    parameter int BufferCount  = 2,
    parameter int IndexWidth   = 1
) (
    input logic clk,
    input logic reset,
    hls_multibuf_channel_if.slave ch
);
    localparam int Depth     = BufferCount * AddressRange;
    localparam int PhysWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [IndexWidth:0]     CountFull  = (IndexWidth + 1)'(BufferCount);
    localparam logic [IndexWidth-1:0]   LastIndex  = IndexWidth'(BufferCount - 1);
    localparam logic [AddressWidth:0]   RangeLimit = (AddressWidth + 1)'(AddressRange);

    logic [IndexWidth-1:0] iptr, tptr, iptr_next, tptr_next;
    logic [IndexWidth:0]   count, count_next;
    logic                  full_n, empty_n;
    logic                  push, pop;

    logic [DataWidth-1:0]  mem [Depth];
    logic [PhysWidth-1:0]  i_phys, t_phys;
    logic                  i_in_range, t_in_range;
    logic [DataWidth-1:0]  i_q, t_q;

    assign push = ch.i_ce & ch.i_write & full_n;
    assign pop  = ch.t_ce & ch.t_read & empty_n;

    // Flush overrides any same-cycle commit or release.
    always_comb begin
        iptr_next  = iptr;
        tptr_next  = tptr;
        count_next = count;
        if (ch.flush) begin
            iptr_next  = '0;
            tptr_next  = '0;
            count_next = '0;
        end else begin
            if (push) begin
                iptr_next = (iptr == LastIndex) ? '0 : iptr + IndexWidth'(1);
            end
            if (pop) begin
                tptr_next = (tptr == LastIndex) ? '0 : tptr + IndexWidth'(1);
            end
            if (push && !pop) begin
                count_next = count + (IndexWidth + 1)'(1);
            end else if (pop && !push) begin
                count_next = count - (IndexWidth + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iptr    <= '0;
            tptr    <= '0;
            count   <= '0;
            full_n  <= 1'b1;
            empty_n <= 1'b0;
        end else begin
            iptr    <= iptr_next;
            tptr    <= tptr_next;
            count   <= count_next;
            full_n  <= (count_next != CountFull);
            empty_n <= (count_next != '0);
        end
    end

    assign ch.i_full_n  = full_n;
    assign ch.t_empty_n = empty_n;
    assign ch.i_count   = count;
    assign ch.t_count   = count;

    // Block-major layout: each buffer owns AddressRange consecutive words.
    assign i_in_range = {1'b0, ch.i_address0} < RangeLimit;
    assign t_in_range = {1'b0, ch.t_address0} < RangeLimit;
    assign i_phys = PhysWidth'(iptr) * PhysWidth'(AddressRange) + PhysWidth'(ch.i_address0);
    assign t_phys = PhysWidth'(tptr) * PhysWidth'(AddressRange) + PhysWidth'(ch.t_address0);

    // The t-port write is issued last so it wins a same-word collision.
    always_ff @(posedge clk) begin
        if (ch.i_ce0 && ch.i_we0 && i_in_range) begin
            mem[i_phys] <= ch.i_d0;
        end
        if (ch.t_ce0 && ch.t_we0 && t_in_range) begin
            mem[t_phys] <= ch.t_d0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_q <= '0;
            t_q <= '0;
        end else begin
            if (ch.i_ce0) begin
                i_q <= i_in_range ? mem[i_phys] : '0;
            end
            if (ch.t_ce0) begin
                t_q <= t_in_range ? mem[t_phys] : '0;
            end
        end
    end

    assign ch.i_q0 = i_q;
    assign ch.t_q0 = t_q;
endmodule

// File: tb/tb_hls_multibuf_channel.sv
// Bench for hls_multibuf_channel with three 4-word buffers: directed scenarios
// followed by random traffic, all compared against a behavioural model.
module tb_hls_multibuf_channel;
    localparam int DW = 16;
    localparam int AR = 4;
    localparam int AW = 3;
    localparam int BC = 3;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hls_multibuf_channel_if #(.DataWidth(DW), .AddressWidth(AW), .IndexWidth(IW)) ch();

    hls_multibuf_channel #(
        .DataWidth(DW), .AddressRange(AR), .AddressWidth(AW),
        .BufferCount(BC), .IndexWidth(IW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ch(ch)
    );

    int total = 0;
    int bad   = 0;

    // Model: buffers are handed out round-robin, so running totals of commits
    // and releases fully determine occupancy and which buffer each side owns.
    int            push_total = 0;
    int            pop_total  = 0;
    logic [DW-1:0] mem_model [BC*AR];
    bit            mem_known [BC*AR];
    logic [DW-1:0] exp_iq, exp_tq;
    bit            iq_known = 0;
    bit            tq_known = 0;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic idle();
        ch.flush      = 0;
        ch.i_ce       = 0;
        ch.i_write    = 0;
        ch.i_ce0      = 0;
        ch.i_we0      = 0;
        ch.i_address0 = '0;
        ch.i_d0       = '0;
        ch.t_ce       = 0;
        ch.t_read     = 0;
        ch.t_ce0      = 0;
        ch.t_we0      = 0;
        ch.t_address0 = '0;
        ch.t_d0       = '0;
    endtask

    task automatic model_edge();
        int  c  = push_total - pop_total;
        int  ip = push_total % BC;
        int  tp = pop_total % BC;
        int  ia = int'(ch.i_address0);
        int  ta = int'(ch.t_address0);
        bit  do_push = ch.i_ce && ch.i_write && (c != BC);
        bit  do_pop  = ch.t_ce && ch.t_read && (c != 0);
        if (reset) begin
            exp_iq = '0; iq_known = 1;
            exp_tq = '0; tq_known = 1;
        end else begin
            if (ch.i_ce0) begin
                if (ia < AR) begin
                    exp_iq = mem_model[ip*AR + ia]; iq_known = mem_known[ip*AR + ia];
                end else begin
                    exp_iq = '0; iq_known = 1;
                end
            end
            if (ch.t_ce0) begin
                if (ta < AR) begin
                    exp_tq = mem_model[tp*AR + ta]; tq_known = mem_known[tp*AR + ta];
                end else begin
                    exp_tq = '0; tq_known = 1;
                end
            end
        end
        if (ch.i_ce0 && ch.i_we0 && ia < AR) begin
            mem_model[ip*AR + ia] = ch.i_d0; mem_known[ip*AR + ia] = 1;
        end
        if (ch.t_ce0 && ch.t_we0 && ta < AR) begin
            mem_model[tp*AR + ta] = ch.t_d0; mem_known[tp*AR + ta] = 1;
        end
        if (reset || ch.flush) begin
            push_total = 0;
            pop_total  = 0;
        end else begin
            if (do_push) push_total++;
            if (do_pop)  pop_total++;
        end
    endtask

    task automatic check_state();
        int c = push_total - pop_total;
        check_output("i_full_n", 32'(ch.i_full_n), 32'(c != BC));
        check_output("t_empty_n", 32'(ch.t_empty_n), 32'(c != 0));
        check_output("i_count", 32'(ch.i_count), c);
        check_output("t_count", 32'(ch.t_count), c);
        if (iq_known) check_output("i_q0", 32'(ch.i_q0), 32'(exp_iq));
        if (tq_known) check_output("t_q0", 32'(ch.t_q0), 32'(exp_tq));
    endtask

    task automatic apply_stimulus();
        model_edge();
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic i_word(input bit we, input int a, input int d);
        ch.i_ce0 = 1; ch.i_we0 = we; ch.i_address0 = AW'(a); ch.i_d0 = DW'(d);
    endtask

    task automatic t_word(input bit we, input int a, input int d);
        ch.t_ce0 = 1; ch.t_we0 = we; ch.t_address0 = AW'(a); ch.t_d0 = DW'(d);
    endtask

    task automatic commit_set();
        ch.i_ce = 1; ch.i_write = 1;
    endtask

    task automatic release_set();
        ch.t_ce = 1; ch.t_read = 1;
    endtask

    initial begin
        for (int i = 0; i < BC*AR; i++) mem_known[i] = 0;
        reset = 1;
        idle();
        apply_stimulus();
        apply_stimulus();
        reset = 0;
        apply_stimulus();
        check_output("reset_iq", 32'(ch.i_q0), 0);
        check_output("reset_full_n", 32'(ch.i_full_n), 1);

        // Release while empty must be ignored.
        idle(); release_set(); apply_stimulus();

        // Fill three buffers; the commit lands on the cycle of the last write.
        for (int b = 1; b <= 3; b++) begin
            for (int w = 0; w < AR; w++) begin
                idle(); i_word(1, w, b*16 + w);
                if (w == AR-1) commit_set();
                apply_stimulus();
            end
        end
        check_output("full_after_3", 32'(ch.i_full_n), 0);
        check_output("count_3", 32'(ch.i_count), 3);
        idle(); commit_set(); apply_stimulus();
        check_output("count_full_hold", 32'(ch.i_count), 3);

        for (int b = 1; b <= 3; b++) begin
            for (int w = 0; w < AR; w++) begin
                idle(); t_word(0, w, 0); apply_stimulus();
                check_output("t_buf_data", 32'(ch.t_q0), b*16 + w);
            end
            idle(); release_set(); apply_stimulus();
        end

        // Fourth commit wraps back to buffer 0.
        for (int w = 0; w < AR; w++) begin
            idle(); i_word(1, w, 16'h40 + w);
            if (w == AR-1) commit_set();
            apply_stimulus();
        end

        // Commit and release together at count 1.
        for (int w = 0; w < AR; w++) begin
            idle(); i_word(1, w, 16'h50 + w);
            if (w == AR-1) begin commit_set(); release_set(); end
            apply_stimulus();
        end
        check_output("count_push_pop", 32'(ch.t_count), 1);
        for (int w = 0; w < AR; w++) begin
            idle(); t_word(0, w, 0); apply_stimulus();
            check_output("t_new_data", 32'(ch.t_q0), 16'h50 + w);
        end

        // Read-first behaviour on the producer port.
        idle(); i_word(1, 2, 16'hAA); apply_stimulus();
        idle(); i_word(1, 2, 16'h55); apply_stimulus();
        check_output("read_first_old", 32'(ch.i_q0), 16'hAA);
        idle(); i_word(0, 2, 0); apply_stimulus();
        check_output("read_first_new", 32'(ch.i_q0), 16'h55);

        // Address beyond the buffer: write dropped, read returns zero.
        idle(); i_word(1, 5, 16'h77); apply_stimulus();
        idle(); i_word(0, 5, 0); apply_stimulus();
        check_output("oob_read", 32'(ch.i_q0), 0);

        // Flush at count 2 beats a same-cycle commit; RAM survives.
        idle(); commit_set(); apply_stimulus();
        check_output("count_2", 32'(ch.i_count), 2);
        idle(); commit_set(); ch.flush = 1; apply_stimulus();
        check_output("flush_count", 32'(ch.i_count), 0);
        check_output("flush_empty_n", 32'(ch.t_empty_n), 0);
        idle(); commit_set(); apply_stimulus();
        for (int w = 0; w < AR; w++) begin
            idle(); t_word(0, w, 0); apply_stimulus();
            check_output("flush_ram_kept", 32'(ch.t_q0), 16'h40 + w);
        end

        // Reset in the middle of a buffer.
        idle(); i_word(0, 0, 0); t_word(0, 1, 0); apply_stimulus();
        idle(); reset = 1; apply_stimulus();
        reset = 0;
        check_output("rst_iq", 32'(ch.i_q0), 0);
        check_output("rst_tq", 32'(ch.t_q0), 0);
        check_output("rst_count", 32'(ch.i_count), 0);

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            idle();
            reset = ($urandom_range(0, 99) == 0);
            ch.flush   = ($urandom_range(0, 39) == 0);
            ch.i_ce    = ($urandom_range(0, 3) != 0);
            ch.i_write = ($urandom_range(0, 2) == 0);
            ch.t_ce    = ($urandom_range(0, 3) != 0);
            ch.t_read  = ($urandom_range(0, 2) == 0);
            if (!reset) begin
                ch.i_ce0 = $urandom_range(0, 1);
                ch.i_we0 = $urandom_range(0, 1);
                ch.t_ce0 = $urandom_range(0, 1);
                ch.t_we0 = $urandom_range(0, 1);
            end
            ch.i_address0 = AW'($urandom_range(0, 5));
            ch.t_address0 = AW'($urandom_range(0, 5));
            ch.i_d0 = DW'($urandom);
            ch.t_d0 = DW'($urandom);
            apply_stimulus();
        end
        reset = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hls_multibuf_channel.md
# hls_multibuf_channel

Parametrised N-buffer dataflow channel between a producer process (i side) and a consumer process (t side) in the streaming dataflow designs. It generalises the two-buffer ping-pong channel to any buffer count from 1 to 2^IndexWidth. It carries its own dual-port memory, uses block-major addressing, and adds occupancy outputs and a synchronous flush. Each side sees one whole buffer at a time through a random-access RAM port; ownership of a buffer passes when the producer commits and the consumer releases.

## Interface
- DataWidth, 32, word width.
- AddressRange, 32, words per buffer.
- AddressWidth, 5, per-buffer address width; AddressRange <= 2^AddressWidth.
- BufferCount, 2, number of buffers; 1 <= BufferCount <= 2^IndexWidth.
- IndexWidth, 1, buffer index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous channel clear; memory contents are kept.
- i_ce  in  1  producer commit qualifier.
- i_write  in  1  producer commit; commits the current buffer when i_ce=1, i_write=1 and i_full_n=1.
- i_full_n  out  1  a buffer is free for the producer.
- i_count  out  IndexWidth+1  committed buffers not yet released.
- i_ce0  in  1  producer RAM port enable.
- i_we0  in  1  producer RAM port write enable.
- i_address0  in  AddressWidth  producer word address.
- i_d0  in  DataWidth  producer write data.
- i_q0  out  DataWidth  producer read data.
- t_ce  in  1  consumer release qualifier.
- t_read  in  1  consumer release; releases the current buffer when t_ce=1, t_read=1 and t_empty_n=1.
- t_empty_n  out  1  at least one committed buffer is available.
- t_count  out  IndexWidth+1  same value as i_count.
- t_ce0  in  1  consumer RAM port enable.
- t_we0  in  1  consumer RAM port write enable.
- t_address0  in  AddressWidth  consumer word address.
- t_d0  in  DataWidth  consumer write data.
- t_q0  out  DataWidth  consumer read data.

## Operation
- Commit and release:
  - push = i_ce & i_write & i_full_n.
  - pop = t_ce & t_read & t_empty_n.
  - A commit while full and a release while empty are ignored and change no state.
- Pointers iptr and tptr (IndexWidth bits):
  - Each advances by 1 on push or pop respectively.
  - Each wraps from BufferCount-1 to 0; wrap is explicit, so non-power-of-2 counts are valid.
- count (IndexWidth+1 bits):
  - push only: +1.
  - pop only: -1.
  - push and pop together, or neither: unchanged.
- Flags are registered:
  - full_n = (next count != BufferCount).
  - empty_n = (next count != 0).
- Memory:
  - Internal RAM of BufferCount*AddressRange words.
  - Physical address = ptr*AddressRange + address, where ptr is iptr for the i port and tptr for the t port.
  - Both ports are true read/write, read-first: a read returns the contents before a same-cycle write on that port.
- Cross-port collision: both ports writing the same physical word in the same cycle leaves the t-port data.
- Out-of-range address (address >= AddressRange): the write is dropped and the read returns 0.
- Ownership rules:
  - The producer must not access its port while i_full_n=0, because iptr then aliases the consumer's buffer.
  - The consumer must not access its port while t_empty_n=0.
  - The channel does not police either rule.
- flush: resets iptr, tptr, count, full_n and empty_n to their reset values. It has priority over push and pop in the same cycle. RAM contents and the q registers are unaffected.
- Reset: behaves as flush and also clears i_q0 and t_q0 to 0. Reset in the middle of a buffer discards all committed buffers.

## Timing
- Reset values:
  - i_full_n=1, t_empty_n=0.
  - i_count=0, t_count=0.
  - i_q0=0, t_q0=0.
- Read latency is 1 cycle: q is valid the cycle after ce0=1 and holds its value while ce0=0.
- Write: the data is in RAM at the edge where ce0=1 and we0=1.
- push at edge k:
  - t_empty_n=1 and the count change are visible from cycle k+1.
  - iptr switches at edge k, so i-port accesses in cycle k+1 target the next buffer.
- pop at edge k: i_full_n rises in cycle k+1 if it was 0.
- Data written in the cycle of the push edge belongs to the committed buffer. The consumer reads it after t_empty_n=1, with minimum 2-cycle producer-write to consumer-q latency.
- Simultaneous push and pop when count=BufferCount is impossible, because push requires full_n=1.
- BufferCount=1:
  - push drives i_full_n to 0 and t_empty_n to 1.
  - pop reverses both.
  - iptr and tptr stay 0.

## Test plan
- Reset, then idle: i_full_n=1, t_empty_n=0, counts=0, q outputs=0. Commit and release attempts with flags unmet leave the state unchanged.
- BufferCount=3, AddressRange=4, IndexWidth=2: fill buffers with 0x1n, 0x2n, 0x3n and commit three times. i_full_n=0 after the third commit, count=3. The consumer then reads 0x10..0x13, 0x20.., 0x30.. in order, releasing after each buffer. The wrap to buffer 0 works on the fourth commit.
- Simultaneous push and pop with count=1 (BufferCount=2): count stays 1, both pointers toggle, flags unchanged. The next consumer read returns the newly committed data.
- Same-cycle read/write on the i port at address 2 (old value 0xAA, new value 0x55): q returns 0xAA in the next cycle, and a subsequent read returns 0x55.
- Out-of-range address 5 with AddressRange=4: the write has no effect on any buffer and the read returns 0.
- flush asserted with count=2 in the same cycle as a push: the next cycle shows count=0, i_full_n=1, t_empty_n=0 and RAM retained. Reset asserted mid-buffer gives the same state and also clears q to 0.
